battle_ctrl_multi: RTL and testbench



---
 rtl/battle_ctrl_multi.sv | 200 ++++++++++++++++++++
 tb/tb_battle_ctrl_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_ctrl_multi.sv
// battle_ctrl_multi
//   Turn-based player-vs-AI battle controller for the PBS game. Each side
//   fields a party of NUM_MON mons; the active mon of each side has an HP
//   register, fainted mons are replaced by the next party slot, and a
//   saturating round counter tracks completed rounds.
//
//   Optional feature macro: PBS_CRIT_EN
//     When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//     steps every clock. A CALC state with lfsr[2:0] == 0 deals double damage
//     (saturating at 2^HP_W-1), and output crit pulses in the following cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   go                single-cycle advance pulse
//   p_power/ai_power  move powers, latched in S_LOAD_PM on go
//   p_hp/ai_hp        active mon HP per side
//   p_idx/ai_idx      active party slot per side
//   damage            last computed damage
//   active_trainer    0 = player attacking, 1 = AI attacking
//   target            1 = AI mon targeted, 0 = player mon targeted
//   apply_damage      high in S_UPDATE_* states
//   round_cnt         completed rounds, saturating
//   state             current state encoding
//   victory/loss      terminal state flags
//   crit              (PBS_CRIT_EN only) critical-hit pulse
module battle_ctrl_multi #(
    parameter int HP_W    = 6,
    parameter int DMG_W   = 4,
    parameter int MAX_HP  = 40,
    parameter int NUM_MON = 3,
    parameter int TURN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DMG_W-1:0]  p_power,
    input  logic [DMG_W-1:0]  ai_power,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic [2:0]        p_idx,
    output logic [2:0]        ai_idx,
    output logic [HP_W-1:0]   damage,
    output logic              active_trainer,
    output logic              target,
    output logic              apply_damage,
    output logic [TURN_W-1:0] round_cnt,
    output logic [3:0]        state,
    output logic              victory,
    output logic              loss
`ifdef PBS_CRIT_EN
    ,
    output logic              crit
`endif
);

    typedef enum logic [3:0] {
        S_LOAD_PM   = 4'd0,
        S_CALC_P    = 4'd1,
        S_UPDATE_AI = 4'd2,
        S_AI_SWITCH = 4'd3,
        S_CALC_AI   = 4'd4,
        S_UPDATE_P  = 4'd5,
        S_P_SWITCH  = 4'd6,
        S_VICTORY   = 4'd7,
        S_LOSS      = 4'd8
    } state_t;

    localparam logic [2:0]      LAST_IDX = 3'(NUM_MON - 1);
    localparam logic [HP_W-1:0] HP_FULL  = HP_W'(MAX_HP);

    state_t              r_state, w_next;
    logic                r_first;      // first cycle spent in the current state
    logic [HP_W-1:0]     r_p_hp, r_ai_hp, r_damage;
    logic [HP_W-1:0]     w_p_hp_new, w_ai_hp_new;
    logic [2:0]          r_p_idx, r_ai_idx;
    logic [DMG_W-1:0]    r_p_pow, r_ai_pow;
    logic [TURN_W-1:0]   r_round, w_round_inc;
    logic [DMG_W-1:0]    w_pow;
    logic [HP_W-1:0]     w_pow_ext, w_dmg, w_p_sub, w_ai_sub;

    assign w_pow     = (r_state == S_CALC_AI) ? r_ai_pow : r_p_pow;
    assign w_pow_ext = HP_W'(w_pow);

`ifdef PBS_CRIT_EN
    logic [15:0]     r_lfsr;
    logic            r_crit, w_crit;
    logic [HP_W:0]   w_dbl;

    assign w_crit = (r_lfsr[2:0] == 3'b000);
    assign w_dbl  = {1'b0, w_pow_ext} << 1;
    // Double damage clamps to the largest representable HP value.
    assign w_dmg  = !w_crit ? w_pow_ext : (w_dbl[HP_W] ? {HP_W{1'b1}} : w_dbl[HP_W-1:0]);
    assign crit   = r_crit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
            r_crit <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            r_crit <= w_crit && (r_state == S_CALC_P || r_state == S_CALC_AI);
        end
    end
`else
    assign w_dmg = w_pow_ext;
`endif

    // Saturating subtraction: damage at or above HP leaves the mon at 0.
    assign w_ai_sub    = (r_damage >= r_ai_hp) ? '0 : r_ai_hp - r_damage;
    assign w_p_sub     = (r_damage >= r_p_hp)  ? '0 : r_p_hp  - r_damage;
    assign w_round_inc = (r_round == {TURN_W{1'b1}}) ? r_round : r_round + 1'b1;

    // Damage lands only on the first cycle of an UPDATE state, and the faint
    // decision looks at the post-damage HP in that same cycle.
    always_comb begin
        w_next      = r_state;
        w_p_hp_new  = r_p_hp;
        w_ai_hp_new = r_ai_hp;
        case (r_state)
            S_LOAD_PM:   if (go) w_next = S_CALC_P;
            S_CALC_P:    w_next = S_UPDATE_AI;
            S_UPDATE_AI: begin
                if (r_first) w_ai_hp_new = w_ai_sub;
                if (w_ai_hp_new == '0)
                    w_next = (r_ai_idx == LAST_IDX) ? S_VICTORY : S_AI_SWITCH;
                else if (go)
                    w_next = S_CALC_AI;
            end
            S_AI_SWITCH: begin
                w_ai_hp_new = HP_FULL;
                w_next      = S_LOAD_PM;
            end
            S_CALC_AI:   w_next = S_UPDATE_P;
            S_UPDATE_P:  begin
                if (r_first) w_p_hp_new = w_p_sub;
                if (w_p_hp_new == '0)
                    w_next = (r_p_idx == LAST_IDX) ? S_LOSS : S_P_SWITCH;
                else if (go)
                    w_next = S_LOAD_PM;
            end
            S_P_SWITCH:  begin
                w_p_hp_new = HP_FULL;
                w_next     = S_LOAD_PM;
            end
            S_VICTORY, S_LOSS: w_next = r_state;
            default:     w_next = S_LOAD_PM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_LOAD_PM;
            r_first  <= 1'b0;
            r_p_hp   <= HP_FULL;
            r_ai_hp  <= HP_FULL;
            r_p_idx  <= '0;
            r_ai_idx <= '0;
            r_damage <= '0;
            r_round  <= '0;
            r_p_pow  <= '0;
            r_ai_pow <= '0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            r_p_hp  <= w_p_hp_new;
            r_ai_hp <= w_ai_hp_new;
            case (r_state)
                S_LOAD_PM: if (go) begin
                    r_p_pow  <= p_power;
                    r_ai_pow <= ai_power;
                end
                S_CALC_P, S_CALC_AI: r_damage <= w_dmg;
                S_AI_SWITCH: begin
                    r_ai_idx <= r_ai_idx + 3'd1;
                    r_round  <= w_round_inc;
                end
                S_P_SWITCH: begin
                    r_p_idx <= r_p_idx + 3'd1;
                    r_round <= w_round_inc;
                end
                S_UPDATE_P: if (w_next == S_LOAD_PM) r_round <= w_round_inc;
                default: ;
            endcase
        end
    end

    assign state          = r_state;
    assign p_hp           = r_p_hp;
    assign ai_hp          = r_ai_hp;
    assign p_idx          = r_p_idx;
    assign ai_idx         = r_ai_idx;
    assign damage         = r_damage;
    assign round_cnt      = r_round;
    assign active_trainer = (r_state == S_CALC_AI) || (r_state == S_UPDATE_P);
    assign target         = (r_state == S_CALC_P)  || (r_state == S_UPDATE_AI);
    assign apply_damage   = (r_state == S_UPDATE_AI) || (r_state == S_UPDATE_P);
    assign victory        = (r_state == S_VICTORY);
    assign loss           = (r_state == S_LOSS);

endmodule

// File: tb/tb_battle_ctrl_multi.sv
// Self-checking bench for battle_ctrl_multi: a 3-mon party instance (a_*)
// and a 1-mon party instance (b_*) share clock, reset and powers; sel picks
// which instance receives go and is observed.
module tb_battle_ctrl_multi;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] php;
        logic [5:0] aihp;
        logic [2:0] pi;
        logic [2:0] ai;
        logic [5:0] dmg;
        logic [7:0] rc;
        logic       at;
        logic       tgt;
        logic       ap;
        logic       vic;
        logic       los;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset, go, sel;
    logic [3:0] p_power, ai_power;
    logic       a_go, b_go;

    logic [5:0] a_php, a_aihp, a_dmg, b_php, b_aihp, b_dmg;
    logic [2:0] a_pi, a_ai, b_pi, b_ai;
    logic       a_at, a_tgt, a_ap, a_vic, a_los, b_at, b_tgt, b_ap, b_vic, b_los;
    logic [7:0] a_rc, b_rc;
    logic [3:0] a_st, b_st;
`ifdef PBS_CRIT_EN
    logic       a_crit, b_crit;
`endif

    assign a_go = go & ~sel;
    assign b_go = go & sel;

    always #5 clk = ~clk;

    battle_ctrl_multi #(.HP_W(6), .DMG_W(4), .MAX_HP(40), .NUM_MON(3), .TURN_W(8)) dut_a (
        .clk(clk), .reset(reset), .go(a_go), .p_power(p_power), .ai_power(ai_power),
        .p_hp(a_php), .ai_hp(a_aihp), .p_idx(a_pi), .ai_idx(a_ai), .damage(a_dmg),
        .active_trainer(a_at), .target(a_tgt), .apply_damage(a_ap), .round_cnt(a_rc),
        .state(a_st), .victory(a_vic), .loss(a_los)
`ifdef PBS_CRIT_EN
        , .crit(a_crit)
`endif
    );

    battle_ctrl_multi #(.HP_W(6), .DMG_W(4), .MAX_HP(40), .NUM_MON(1), .TURN_W(8)) dut_b (
        .clk(clk), .reset(reset), .go(b_go), .p_power(p_power), .ai_power(ai_power),
        .p_hp(b_php), .ai_hp(b_aihp), .p_idx(b_pi), .ai_idx(b_ai), .damage(b_dmg),
        .active_trainer(b_at), .target(b_tgt), .apply_damage(b_ap), .round_cnt(b_rc),
        .state(b_st), .victory(b_vic), .loss(b_los)
`ifdef PBS_CRIT_EN
        , .crit(b_crit)
`endif
    );

    int n_pass = 0;
    int n_tot  = 0;
    snap_t exp_q[$];
    snap_t obs_q[$];

    // reference model of the selected instance
    int m_st, m_php, m_aihp, m_pi, m_ai, m_dmg, m_rc;

    function automatic snap_t mk();
        snap_t s;
        s.st   = 4'(m_st);
        s.php  = 6'(m_php);
        s.aihp = 6'(m_aihp);
        s.pi   = 3'(m_pi);
        s.ai   = 3'(m_ai);
        s.dmg  = 6'(m_dmg);
        s.rc   = 8'(m_rc);
        s.at   = (m_st == 4 || m_st == 5);
        s.tgt  = (m_st == 1 || m_st == 2);
        s.ap   = (m_st == 2 || m_st == 5);
        s.vic  = (m_st == 7);
        s.los  = (m_st == 8);
        return s;
    endfunction

    function automatic snap_t obs();
        if (sel)
            return '{b_st, b_php, b_aihp, b_pi, b_ai, b_dmg, b_rc, b_at, b_tgt, b_ap, b_vic, b_los};
        return '{a_st, a_php, a_aihp, a_pi, a_ai, a_dmg, a_rc, a_at, a_tgt, a_ap, a_vic, a_los};
    endfunction

    // Called at a negedge: present go for one posedge, record the result.
    task automatic step(input logic g);
        go = g;
        @(negedge clk);
        go = 1'b0;
        obs_q.push_back(obs());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_st = 0; m_php = 40; m_aihp = 40; m_pi = 0; m_ai = 0; m_dmg = 0; m_rc = 0;
    endtask

    function automatic int rc_inc(input int rc);
        return (rc == 255) ? 255 : rc + 1;
    endfunction

    // One full round: player attack, then (if the AI mon survived) AI attack.
    task automatic play_round(input int pp, input int ap);
        int nm;
        nm = sel ? 1 : 3;
        p_power  = 4'(pp);
        ai_power = 4'(ap);
        m_st = 1;                    exp_q.push_back(mk()); step(1'b1);
        m_st = 2; m_dmg = pp;        exp_q.push_back(mk()); step(1'b0);
        m_aihp = (pp >= m_aihp) ? 0 : m_aihp - pp;
        if (m_aihp == 0) m_st = (m_ai == nm - 1) ? 7 : 3;
        exp_q.push_back(mk()); step(1'b0);
        if (m_st == 7) return;
        if (m_st == 3) begin
            m_ai++; m_aihp = 40; m_rc = rc_inc(m_rc); m_st = 0;
            exp_q.push_back(mk()); step(1'b0);
            return;
        end
        m_st = 4;                    exp_q.push_back(mk()); step(1'b1);
        m_st = 5; m_dmg = ap;        exp_q.push_back(mk()); step(1'b0);
        m_php = (ap >= m_php) ? 0 : m_php - ap;
        if (m_php == 0) m_st = (m_pi == nm - 1) ? 8 : 6;
        exp_q.push_back(mk()); step(1'b0);
        if (m_st == 8) return;
        if (m_st == 6) begin
            m_pi++; m_php = 40; m_rc = rc_inc(m_rc); m_st = 0;
            exp_q.push_back(mk()); step(1'b0);
            return;
        end
        m_st = 0; m_rc = rc_inc(m_rc); exp_q.push_back(mk()); step(1'b1);
    endtask

    task automatic test_reset();
        snap_t e, o;
        sel = 1'b0;
        do_reset();
        e = mk();
        o = obs();
        n_tot++;
        if (o !== e) $display("FAIL reset: got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_basic();
        snap_t e, o;
        do_reset();
        play_round(5, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tot++;
            if (o !== e) $display("FAIL basic_seq: got %h want %h", o, e);
            else n_pass++;
        end
        n_tot++;
        if ({a_st, a_php, a_aihp, a_rc} !== {4'd0, 6'd37, 6'd35, 8'd1})
            $display("FAIL basic_end: got st=%0d php=%0d aihp=%0d rc=%0d want 0/37/35/1",
                     a_st, a_php, a_aihp, a_rc);
        else n_pass++;
    endtask

    task automatic test_saturate_switch();
        snap_t e, o;
        do_reset();
        for (int r = 0; r < 3; r++) play_round(15, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tot++;
            if (o !== e) $display("FAIL sat_switch_seq: got %h want %h", o, e);
            else n_pass++;
        end
        n_tot++;
        if ({a_st, a_ai, a_aihp, a_php, a_rc} !== {4'd0, 3'd1, 6'd40, 6'd40, 8'd3})
            $display("FAIL sat_switch_end: got st=%0d ai=%0d aihp=%0d php=%0d rc=%0d want 0/1/40/40/3",
                     a_st, a_ai, a_aihp, a_php, a_rc);
        else n_pass++;
    endtask

    // Continues from the post-switch state so indices/round are non-zero.
    task automatic test_reset_mid();
        p_power  = 4'd5;
        ai_power = 4'd3;
        step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        obs_q.delete();
        n_tot++;
        if ({a_st, a_php, a_ap} !== {4'd5, 6'd37, 1'b1})
            $display("FAIL mid_hold: got st=%0d php=%0d ap=%0d want 5/37/1", a_st, a_php, a_ap);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tot++;
        if ({a_st, a_php, a_aihp, a_pi, a_ai, a_rc, a_dmg} !== {4'd0, 6'd40, 6'd40, 3'd0, 3'd0, 8'd0, 6'd0})
            $display("FAIL mid_reset: got st=%0d php=%0d aihp=%0d pi=%0d ai=%0d rc=%0d dmg=%0d want 0/40/40/0/0/0/0",
                     a_st, a_php, a_aihp, a_pi, a_ai, a_rc, a_dmg);
        else n_pass++;
    endtask

    task automatic test_victory();
        snap_t e, o;
        sel = 1'b1;
        do_reset();
        for (int r = 0; r < 3; r++) play_round(15, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tot++;
            if (o !== e) $display("FAIL victory_seq: got %h want %h", o, e);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) step(1'b1);
        obs_q.delete();
        n_tot++;
        if ({b_st, b_vic, b_aihp, b_rc} !== {4'd7, 1'b1, 6'd0, 8'd2})
            $display("FAIL victory_hold: got st=%0d vic=%0d aihp=%0d rc=%0d want 7/1/0/2",
                     b_st, b_vic, b_aihp, b_rc);
        else n_pass++;
        do_reset();
        n_tot++;
        if ({b_st, b_vic, b_php, b_aihp} !== {4'd0, 1'b0, 6'd40, 6'd40})
            $display("FAIL victory_reset: got st=%0d vic=%0d php=%0d aihp=%0d want 0/0/40/40",
                     b_st, b_vic, b_php, b_aihp);
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_loss();
        snap_t e, o;
        int aps[10];
        aps = '{15, 15, 15, 15, 15, 15, 15, 15, 6, 15};
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < 10; r++) play_round(0, aps[r]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tot++;
            if (o !== e) $display("FAIL loss_seq: got %h want %h", o, e);
            else n_pass++;
        end
        for (int k = 0; k < 2; k++) step(1'b1);
        obs_q.delete();
        n_tot++;
        if ({a_st, a_los, a_pi, a_php, a_aihp} !== {4'd8, 1'b1, 3'd2, 6'd0, 6'd40})
            $display("FAIL loss_end: got st=%0d loss=%0d pi=%0d php=%0d aihp=%0d want 8/1/2/0/40",
                     a_st, a_los, a_pi, a_php, a_aihp);
        else n_pass++;
    endtask

    task automatic test_round_sat();
        snap_t e, o;
        do_reset();
        for (int r = 0; r < 258; r++) begin
            play_round(0, 0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_tot++;
                if (o !== e) $display("FAIL round_sat_seq r%0d: got %h want %h", r, o, e);
                else n_pass++;
            end
        end
        n_tot++;
        if (a_rc !== 8'd255) $display("FAIL round_sat_end: got rc=%0d want 255", a_rc);
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        go       = 1'b0;
        sel      = 1'b0;
        p_power  = '0;
        ai_power = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturate_switch();
        test_reset_mid();
        test_victory();
        test_loss();
        test_round_sat();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
